io_event_ctrl: RTL and testbench

IO_EVENT_CTRL -- requirements
Module: io_event_ctrl

---
 rtl/io_event_ctrl.sv | 156 +++++++++++++++
 tb/tb_io_event_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_event_ctrl.sv
// Input-port event controller: captures port samples into a small FIFO and raises
// one-cycle key events to the CPU. Optional macro IO_EVENT_CHANGE_FILTER_EN selects change-detect capture.
module io_event_ctrl #(
    parameter int DEPTH      = 4,
    parameter int HOLDOFF    = 3,
    parameter int SAMPLE_DIV = 6
) (
    input  logic       CK,
    input  logic       RST,
    input  logic [7:0] in_port,
    input  logic       ack,
    input  logic       ovf_clr,
    output logic       key_event,
    output logic [7:0] data_out,
    output logic [4:0] count,
    output logic       busy,
    output logic       overflow
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULL_CNT  = 5'(DEPTH);
    localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE,
        S_HOLDOFF
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [3:0]      r_holdCnt;
    logic [3:0]      w_holdNext;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [4:0]      r_count;
    logic            r_overflow;
    logic [7:0]      r_lastPushed;
    logic            w_pushReq;
    logic            w_pop;
    logic            w_pushAcc;
    logic            w_drop;
    logic            w_full;

`ifdef IO_EVENT_CHANGE_FILTER_EN
    assign w_pushReq = (in_port != r_lastPushed);
`else
    localparam logic [7:0] DIV_LAST = 8'(SAMPLE_DIV - 1);
    logic [7:0] r_divCnt;

    always_ff @(posedge CK) begin
        if (RST) begin
            r_divCnt <= '0;
        end else if (r_divCnt == DIV_LAST) begin
            r_divCnt <= '0;
        end else begin
            r_divCnt <= r_divCnt + 8'd1;
        end
    end

    assign w_pushReq = (r_divCnt == DIV_LAST);
`endif

    // A pop frees the slot first, so a push into a full FIFO alongside a pop is accepted.
    assign w_full    = (r_count == FULL_CNT);
    assign w_pop     = (r_state == S_SERVICE) && ack && (r_count != 5'd0);
    assign w_pushAcc = w_pushReq && (!w_full || w_pop);
    assign w_drop    = w_pushReq && w_full && !w_pop;

    always_ff @(posedge CK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_count      <= '0;
            r_lastPushed <= '0;
        end else begin
            if (w_pushAcc) begin
                r_mem[r_wrPtr] <= in_port;
                r_wrPtr        <= r_wrPtr + AW'(1);
                r_lastPushed   <= in_port;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_pushAcc && !w_pop) begin
                r_count <= r_count + 5'd1;
            end else if (w_pop && !w_pushAcc) begin
                r_count <= r_count - 5'd1;
            end
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_holdCnt <= '0;
        end else begin
            r_state   <= w_nextState;
            r_holdCnt <= w_holdNext;
        end
    end

    // SERVICE has no timeout: the CPU must acknowledge every event it is given.
    always_comb begin
        w_nextState = r_state;
        w_holdNext  = r_holdCnt;
        case (r_state)
            S_IDLE: begin
                if (r_count != 5'd0) begin
                    w_nextState = S_REQ;
                end
            end
            S_REQ: begin
                w_nextState = S_SERVICE;
            end
            S_SERVICE: begin
                if (ack) begin
                    w_nextState = S_HOLDOFF;
                    w_holdNext  = HOLD_LOAD;
                end
            end
            S_HOLDOFF: begin
                if (r_holdCnt == 4'd0) begin
                    w_nextState = S_IDLE;
                end else begin
                    w_holdNext = r_holdCnt - 4'd1;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign key_event = (r_state == S_REQ);
    assign busy      = (r_state == S_REQ) || (r_state == S_SERVICE);
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign data_out  = (r_count != 5'd0) ? r_mem[r_rdPtr] : 8'd0;

endmodule

// File: tb/tb_io_event_ctrl.sv
// Self-checking bench for io_event_ctrl: directed vector table, randomized run against
// a queue-based reference model, and hand-written full-FIFO / reset-mid-service sequences.
module tb_io_event_ctrl;

    localparam int DEPTH      = 4;
    localparam int HOLDOFF    = 3;
    localparam int SAMPLE_DIV = 6;

    localparam int PH_IDLE    = 0;
    localparam int PH_REQ     = 1;
    localparam int PH_SERVICE = 2;
    localparam int PH_HOLD    = 3;

    logic       CK = 1'b0;
    logic       RST;
    logic [7:0] in_port;
    logic       ack;
    logic       ovf_clr;
    logic       key_event;
    logic [7:0] data_out;
    logic [4:0] count;
    logic       busy;
    logic       overflow;

    int passed;
    int total;

    io_event_ctrl #(
        .DEPTH     (DEPTH),
        .HOLDOFF   (HOLDOFF),
        .SAMPLE_DIV(SAMPLE_DIV)
    ) dut (
        .CK       (CK),
        .RST      (RST),
        .in_port  (in_port),
        .ack      (ack),
        .ovf_clr  (ovf_clr),
        .key_event(key_event),
        .data_out (data_out),
        .count    (count),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 CK = ~CK;

    // Reference model: FIFO as a queue, phase as a plain integer, sampling from a cycle count.
    logic [7:0] mQ [$];
    bit         mOvf;
    int         mPhase;
    int         mHold;
    int         mCycles;
    logic [7:0] mLast;

    function automatic bit modelPushReq(input logic [7:0] inp);
`ifdef IO_EVENT_CHANGE_FILTER_EN
        return inp != mLast;
`else
        return (mCycles % SAMPLE_DIV) == (SAMPLE_DIV - 1);
`endif
    endfunction

    task automatic modelEdge(input bit rst, input logic [7:0] inp, input bit a, input bit clr);
        int sizeBefore;
        bit req;
        bit pop;
        bit drop;
        if (rst) begin
            mQ.delete();
            mOvf    = 1'b0;
            mPhase  = PH_IDLE;
            mHold   = 0;
            mCycles = 0;
            mLast   = 8'd0;
            return;
        end
        sizeBefore = mQ.size();
        req  = modelPushReq(inp);
        pop  = (mPhase == PH_SERVICE) && a && (sizeBefore > 0);
        drop = 1'b0;
        if (pop) void'(mQ.pop_front());
        if (req) begin
            if (mQ.size() < DEPTH) begin
                mQ.push_back(inp);
                mLast = inp;
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) mOvf = 1'b1;
        else if (clr) mOvf = 1'b0;
        case (mPhase)
            PH_IDLE:    if (sizeBefore > 0) mPhase = PH_REQ;
            PH_REQ:     mPhase = PH_SERVICE;
            PH_SERVICE: if (a) begin mPhase = PH_HOLD; mHold = HOLDOFF - 1; end
            default: begin
                if (mHold == 0) mPhase = PH_IDLE;
                else mHold = mHold - 1;
            end
        endcase
        mCycles++;
    endtask

    task automatic applyStimulus(input bit rst, input logic [7:0] inp, input bit a, input bit clr);
        RST     = rst;
        in_port = inp;
        ack     = a;
        ovf_clr = clr;
        @(posedge CK);
        modelEdge(rst, inp, a, clr);
        #1;
    endtask

    task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic checkOutput(input string name, input int eCount, input bit eKey, input bit eBusy,
                               input bit eOvf, input int eData);
        checkField({name, "_count"}, 32'(count), eCount);
        checkField({name, "_key"}, 32'(key_event), 32'(eKey));
        checkField({name, "_busy"}, 32'(busy), 32'(eBusy));
        checkField({name, "_ovf"}, 32'(overflow), 32'(eOvf));
        checkField({name, "_data"}, 32'(data_out), eData);
    endtask

    task automatic checkModel(input string name);
        int eData;
        eData = (mQ.size() > 0) ? int'(mQ[0]) : 0;
        checkOutput(name, mQ.size(), mPhase == PH_REQ, (mPhase == PH_REQ) || (mPhase == PH_SERVICE),
                    mOvf, eData);
    endtask

    typedef struct {
        int         reps;
        bit         rst;
        logic [7:0] inp;
        bit         ack;
        bit         clr;
        int         eCount;
        bit         eKey;
        bit         eBusy;
        bit         eOvf;
        int         eData;
    } vec_t;

    vec_t vecs [$];

    function automatic void addVec(input int reps, input bit rst, input int inp, input bit a, input bit clr,
                                   input int eCount, input bit eKey, input bit eBusy, input bit eOvf,
                                   input int eData);
        vec_t v;
        v.reps = reps; v.rst = rst; v.inp = 8'(inp); v.ack = a; v.clr = clr;
        v.eCount = eCount; v.eKey = eKey; v.eBusy = eBusy; v.eOvf = eOvf; v.eData = eData;
        vecs.push_back(v);
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        RST     = 1'b1;
        in_port = 8'd0;
        ack     = 1'b0;
        ovf_clr = 1'b0;
        passed  = 0;
        total   = 0;

`ifdef IO_EVENT_CHANGE_FILTER_EN
        addVec(1, 1,   0, 0, 0,  0, 0, 0, 0,  0);
        addVec(2, 0,   0, 0, 0,  0, 0, 0, 0,  0);
        addVec(1, 0,  20, 0, 0,  1, 0, 0, 0, 20);
        addVec(1, 0,  20, 0, 0,  1, 1, 1, 0, 20);
        addVec(1, 0,  20, 0, 0,  1, 0, 1, 0, 20);
        addVec(1, 0,  20, 1, 0,  0, 0, 0, 0,  0);
        addVec(3, 0,  20, 0, 0,  0, 0, 0, 0,  0);
        addVec(1, 0,  40, 0, 0,  1, 0, 0, 0, 40);
        addVec(1, 0,  60, 0, 0,  2, 1, 1, 0, 40);
        addVec(1, 0,  80, 0, 0,  3, 0, 1, 0, 40);
        addVec(1, 0, 100, 0, 0,  4, 0, 1, 0, 40);
        addVec(1, 0, 120, 0, 0,  4, 0, 1, 1, 40);
        addVec(1, 0, 120, 0, 1,  4, 0, 1, 1, 40);
        addVec(1, 0, 100, 0, 1,  4, 0, 1, 0, 40);
        addVec(1, 0, 100, 1, 0,  3, 0, 0, 0, 60);
`else
        addVec(1, 1, 55, 0, 0,  0, 0, 0, 0,  0);
        addVec(5, 0, 55, 0, 0,  0, 0, 0, 0,  0);
        addVec(1, 0, 55, 0, 0,  1, 0, 0, 0, 55);
        addVec(1, 0, 55, 0, 0,  1, 1, 1, 0, 55);
        addVec(1, 0, 55, 0, 0,  1, 0, 1, 0, 55);
        addVec(1, 0, 55, 1, 0,  0, 0, 0, 0,  0);
        addVec(1, 0, 55, 1, 0,  0, 0, 0, 0,  0);
        addVec(1, 0, 55, 0, 0,  0, 0, 0, 0,  0);
        addVec(1, 0, 55, 0, 0,  1, 0, 0, 0, 55);
        addVec(1, 0, 77, 0, 0,  1, 1, 1, 0, 55);
        addVec(4, 0, 77, 0, 0,  1, 0, 1, 0, 55);
        addVec(1, 0, 77, 0, 0,  2, 0, 1, 0, 55);
        addVec(5, 0, 77, 0, 0,  2, 0, 1, 0, 55);
        addVec(1, 0, 77, 0, 0,  3, 0, 1, 0, 55);
        addVec(5, 0, 77, 0, 0,  3, 0, 1, 0, 55);
        addVec(1, 0, 77, 0, 0,  4, 0, 1, 0, 55);
        addVec(5, 0, 77, 0, 0,  4, 0, 1, 0, 55);
        addVec(1, 0, 77, 0, 0,  4, 0, 1, 1, 55);
        addVec(1, 0, 77, 0, 1,  4, 0, 1, 0, 55);
        addVec(1, 0, 77, 1, 0,  3, 0, 0, 0, 77);
        addVec(3, 0, 77, 0, 0,  3, 0, 0, 0, 77);
        addVec(1, 0, 77, 0, 0,  4, 1, 1, 0, 77);
`endif
        addVec(1, 1, 9, 1, 0,  0, 0, 0, 0,  0);

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                applyStimulus(vecs[i].rst, vecs[i].inp, vecs[i].ack, vecs[i].clr);
                checkOutput($sformatf("vec%0d_%0d", i, r), vecs[i].eCount, vecs[i].eKey,
                            vecs[i].eBusy, vecs[i].eOvf, vecs[i].eData);
            end
        end

        applyStimulus(1'b1, 8'd0, 1'b0, 1'b0);
        checkModel("rand_reset");
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] rIn;
            bit         rAck;
            bit         rClr;
            bit         rRst;
            int         ackBias;
            ackBias = (i / 250) % 4;
            rIn  = 8'($urandom_range(0, 3) * 20);
            rAck = ($urandom_range(0, 3) < ackBias);
            rClr = ($urandom_range(0, 7) == 0);
            rRst = ($urandom_range(0, 149) == 0);
            applyStimulus(rRst, rIn, rAck, rClr);
            checkModel($sformatf("rand%0d", i));
        end

        applyStimulus(1'b1, 8'd0, 1'b0, 1'b0);
        checkModel("corner_reset");
        k = 0;
        while (!(mQ.size() == DEPTH && mPhase == PH_SERVICE) && k < 200) begin
`ifdef IO_EVENT_CHANGE_FILTER_EN
            applyStimulus(1'b0, 8'(k + 1), 1'b0, 1'b0);
`else
            applyStimulus(1'b0, 8'd55, 1'b0, 1'b0);
`endif
            checkModel("corner_fill");
            k++;
        end
        checkField("corner_fill_bound", 32'(k < 200), 32'd1);
`ifndef IO_EVENT_CHANGE_FILTER_EN
        k = 0;
        while (!modelPushReq(mLast) && k < 50) begin
            applyStimulus(1'b0, mLast, 1'b0, 1'b0);
            checkModel("corner_wait");
            k++;
        end
        checkField("corner_wait_bound", 32'(k < 50), 32'd1);
`endif
        applyStimulus(1'b0, mLast + 8'd1, 1'b1, 1'b0);
        checkField("full_push_pop_count", 32'(count), 32'(DEPTH));
        checkField("full_push_pop_ovf", 32'(overflow), 32'd0);
        checkModel("full_push_pop");

        k = 0;
        while (mPhase != PH_SERVICE && k < 50) begin
            applyStimulus(1'b0, mLast, 1'b0, 1'b0);
            checkModel("corner_reenter");
            k++;
        end
        checkField("corner_reenter_bound", 32'(k < 50), 32'd1);
        applyStimulus(1'b1, mLast + 8'd3, 1'b1, 1'b0);
        checkOutput("reset_mid_service", 0, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
        checkOutput("after_reset", 0, 1'b0, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
